// File: rtl/ram_mrp_clr.sv
// Single-write, multi-read synchronous RAM with selectable read latency and collision mode.
// A sequential clear engine zeroes the array after reset or on request.
module ram_mrp_clr #(
  parameter int    DSIZE          = 8,
  parameter int    ASIZE          = 10,
  parameter int    NRD            = 2,
  parameter int    READ_LATENCY   = 1,
  parameter int    WR_MODE        = 0,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = ""
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_req,
  output logic                   rdy,
  input  logic                   wec,
  input  logic [ASIZE-1:0]       addrc,
  input  logic [DSIZE-1:0]       dinc,
  input  logic [NRD-1:0]         en,
  input  logic [NRD*ASIZE-1:0]   addr,
  output logic [NRD*DSIZE-1:0]   dout,
  output logic [NRD-1:0]         dout_vld
);

  // state   | meaning
  // S_READY | normal read/write service (rdy high one edge after reset)
  // S_CLEAR | writing zero to address cnt, host traffic dropped
  typedef enum logic {S_READY, S_CLEAR} state_t;

  localparam int             DEPTH    = 2**ASIZE;
  localparam logic [ASIZE:0] CNT_LAST = (ASIZE+1)'(DEPTH-1);

  state_t               state;
  logic [ASIZE:0]       cnt;
  logic [DSIZE-1:0]     mem [DEPTH];

  logic                 wr_acc;
  logic [NRD-1:0]       rd_acc;
  logic                 mem_we;
  logic [ASIZE-1:0]     mem_wa;
  logic [DSIZE-1:0]     mem_wd;
  logic [NRD*DSIZE-1:0] rd_data;
  logic [NRD*DSIZE-1:0] s1_data;
  logic [NRD-1:0]       s1_vld;

  initial begin
    for (int j = 0; j < DEPTH; j++) mem[j] = '0;
  end

  assign wr_acc = wec & rdy;
  assign rd_acc = en & {NRD{rdy}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      cnt   <= '0;
      rdy   <= 1'b0;
    end else begin
      case (state)
        S_READY: begin
          if (rdy && clr_req) begin
            state <= S_CLEAR;
            cnt   <= '0;
            rdy   <= 1'b0;
          end else begin
            rdy   <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (cnt == CNT_LAST) begin
            state <= S_READY;
            cnt   <= '0;
            rdy   <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        default: state <= S_READY;
      endcase
    end
  end

  always_comb begin
    mem_we = wr_acc;
    mem_wa = addrc;
    mem_wd = dinc;
    if (state == S_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = cnt[ASIZE-1:0];
      mem_wd = '0;
    end
  end

  // RAM array itself is never reset; contents survive rst_n.
  always @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (WR_MODE == 1 && wr_acc && addr[i*ASIZE +: ASIZE] == addrc)
        rd_data[i*DSIZE +: DSIZE] = dinc;
      else
        rd_data[i*DSIZE +: DSIZE] = mem[addr[i*ASIZE +: ASIZE]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_vld  <= '0;
    end else begin
      s1_vld <= rd_acc;
      for (int i = 0; i < NRD; i++) begin
        if (rd_acc[i]) s1_data[i*DSIZE +: DSIZE] <= rd_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // Output stage is not gated by state so reads in flight drain into CLEAR.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout     <= '0;
          dout_vld <= '0;
        end else begin
          dout_vld <= s1_vld;
          for (int i = 0; i < NRD; i++) begin
            if (s1_vld[i]) dout[i*DSIZE +: DSIZE] <= s1_data[i*DSIZE +: DSIZE];
          end
        end
      end
    end else begin : g_lat1
      assign dout     = s1_data;
      assign dout_vld = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_ram_mrp_clr.sv
// Bench for ram_mrp_clr: two configurations share stimulus; a behavioural model
// pushes expected read results into per-port queues, popped when dout_vld fires.
module tb_ram_mrp_clr;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_req;
  logic        wec;
  logic [3:0]  addrc;
  logic [7:0]  dinc;
  logic [3:0]  en;
  logic [15:0] addr;
  logic [15:0] dout_a;
  logic [1:0]  vld_a;
  logic        rdy_a;
  logic [31:0] dout_b;
  logic [3:0]  vld_b;
  logic        rdy_b;

  always #5 clk = ~clk;

  ram_mrp_clr #(.DSIZE(DW), .ASIZE(AW), .NRD(2), .READ_LATENCY(1), .WR_MODE(0),
                .CLEAR_ON_RESET(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .rdy(rdy_a), .wec(wec),
    .addrc(addrc), .dinc(dinc), .en(en[1:0]), .addr(addr[7:0]),
    .dout(dout_a), .dout_vld(vld_a));

  ram_mrp_clr #(.DSIZE(DW), .ASIZE(AW), .NRD(4), .READ_LATENCY(2), .WR_MODE(1),
                .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .rdy(rdy_b), .wec(wec),
    .addrc(addrc), .dinc(dinc), .en(en), .addr(addr),
    .dout(dout_b), .dout_vld(vld_b));

  typedef struct {
    logic [7:0] data;
    logic       care;
    int         due;
  } exp_t;

  exp_t       sb [8][$];
  logic [7:0] mm [2][DEPTH];
  logic       mk [2][DEPTH];
  logic       m_clr [2];
  logic       m_rdy [2];
  int         m_cnt [2];
  int         cyc;
  logic [7:0] last [8];
  logic       lk [8];
  int         n_tests;
  int         n_fail;

  function automatic int nrd(input int k);
    return (k == 0) ? 2 : 4;
  endfunction
  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model, evaluated on the same edges as the DUTs.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    logic [3:0] ra;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (m_clr[k]) for (int a = 0; a < DEPTH; a++) mk[k][a] = 1'b0;
        m_clr[k] = (k == 1);
        m_rdy[k] = 1'b0;
        m_cnt[k] = 0;
      end
      for (int j = 0; j < 8; j++) sb[j].delete();
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (m_clr[k]) begin
          if (m_cnt[k] == DEPTH-1) begin
            for (int a = 0; a < DEPTH; a++) begin
              mm[k][a] = 8'h00;
              mk[k][a] = 1'b1;
            end
            m_clr[k] = 1'b0;
            m_rdy[k] = 1'b1;
            m_cnt[k] = 0;
          end else m_cnt[k]++;
        end else if (!m_rdy[k]) begin
          m_rdy[k] = 1'b1;
        end else begin
          for (int p = 0; p < nrd(k); p++) begin
            if (en[p]) begin
              ra = addr[p*4 +: 4];
              e.due = cyc + lat(k) - 1;
              if (k == 1 && wec && ra == addrc) begin
                e.data = dinc;
                e.care = 1'b1;
              end else begin
                e.data = mm[k][ra];
                e.care = mk[k][ra];
              end
              sb[k*4+p].push_back(e);
            end
          end
          if (wec) begin
            mm[k][addrc] = dinc;
            mk[k][addrc] = 1'b1;
          end
          if (clr_req) begin
            m_clr[k] = 1'b1;
            m_rdy[k] = 1'b0;
            m_cnt[k] = 0;
          end
        end
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t       e;
    logic       v;
    logic [7:0] d;
    int         j;
    if (!rst_n) begin
      for (int q = 0; q < 8; q++) begin
        last[q] = 8'h00;
        lk[q]   = 1'b1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < nrd(k); p++) begin
          j = k*4 + p;
          v = (k == 0) ? vld_a[p] : vld_b[p];
          d = (k == 0) ? dout_a[p*8 +: 8] : dout_b[p*8 +: 8];
          if (v) begin
            if (sb[j].size() == 0) begin
              check($sformatf("unexpected_vld_%s%0d", k ? "b" : "a", p), 32'd1, 32'd0);
              lk[j] = 1'b0;
            end else begin
              e = sb[j].pop_front();
              check($sformatf("latency_%s%0d", k ? "b" : "a", p), cyc, e.due);
              if (e.care) check($sformatf("rd_data_%s%0d", k ? "b" : "a", p), 32'(d), 32'(e.data));
              last[j] = e.data;
              lk[j]   = e.care;
            end
          end else begin
            if (sb[j].size() > 0 && sb[j][0].due <= cyc) begin
              check($sformatf("missing_vld_%s%0d", k ? "b" : "a", p), 32'd0, 32'd1);
              void'(sb[j].pop_front());
            end
            if (lk[j]) check($sformatf("dout_hold_%s%0d", k ? "b" : "a", p), 32'(d), 32'(last[j]));
          end
        end
      end
    end
  end

  task automatic set_in(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                        input logic [3:0] e, input logic [15:0] ad, input logic c);
    wec = w; addrc = wa; dinc = wd; en = e; addr = ad; clr_req = c;
  endtask

  task automatic op(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                    input logic [3:0] e, input logic [15:0] ad, input logic c);
    @(negedge clk); #1;
    set_in(w, wa, wd, e, ad, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 4'h0, 8'h00, 4'h0, 16'h0000, 1'b0);
  endtask

  task automatic rand_in(input logic allow_clr);
    logic [3:0]  wa;
    logic [15:0] ad;
    wa = 4'($urandom_range(0, 15));
    for (int p = 0; p < 4; p++) ad[p*4 +: 4] = ($urandom_range(0, 1) == 1) ? wa : 4'($urandom_range(0, 15));
    set_in(1'($urandom_range(0, 1)), wa, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), ad,
           allow_clr ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic measure_rdy(input int ea, input int eb);
    int ta;
    int tb;
    ta = -1;
    tb = -1;
    for (int n = 1; n <= 200 && (ta < 0 || tb < 0); n++) begin
      @(negedge clk); #1;
      if (rdy_a && ta < 0) ta = n;
      if (rdy_b && tb < 0) tb = n;
    end
    check("rdy_rise_a", ta, ea);
    check("rdy_rise_b", tb, eb);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      logic [3:0] a4;
      a4 = 4'(a);
      op(1'b0, 4'h0, 8'h00, 4'hF, {a4, a4, a4, a4}, 1'b0);
    end
    idle(3);
  endtask

  initial begin
    int la;
    int lb;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    for (int k = 0; k < 2; k++) begin
      m_clr[k] = 1'b0;
      m_rdy[k] = 1'b0;
      m_cnt[k] = 0;
      for (int a = 0; a < DEPTH; a++) begin
        mm[k][a] = 8'h00;
        mk[k][a] = 1'b1;
      end
    end
    rst_n = 1'b0;
    set_in(1'b0, 4'h0, 8'h00, 4'h0, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_dout_a", 32'(dout_a), 32'd0);
    check("rst_vld_a",  32'(vld_a),  32'd0);
    check("rst_rdy_a",  32'(rdy_a),  32'd0);
    check("rst_dout_b", dout_b,      32'd0);
    check("rst_vld_b",  32'(vld_b),  32'd0);
    check("rst_rdy_b",  32'(rdy_b),  32'd0);
    rst_n = 1'b1;
    measure_rdy(1, 16);

    // Basic write then read on port 0.
    op(1'b1, 4'd3, 8'hA5, 4'h0, 16'h0000, 1'b0);
    op(1'b0, 4'd0, 8'h00, 4'h1, 16'h0003, 1'b0);
    idle(3);
    // Collision on ports 0/1, then a plain read-back.
    op(1'b1, 4'd5, 8'h11, 4'h0, 16'h0000, 1'b0);
    op(1'b1, 4'd5, 8'h22, 4'h3, 16'h0055, 1'b0);
    op(1'b0, 4'd0, 8'h00, 4'hF, 16'h5555, 1'b0);
    idle(3);
    // Every port reading the same word.
    op(1'b1, 4'd7, 8'h3C, 4'h0, 16'h0000, 1'b0);
    op(1'b0, 4'd0, 8'h00, 4'hF, 16'h7777, 1'b0);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      rand_in(1'b0);
    end
    idle(3);

    // Bulk clear with reads issued on the request edge draining into CLEAR.
    for (int a = 0; a < DEPTH; a++) op(1'b1, 4'(a), 8'hFF, 4'h0, 16'h0000, 1'b0);
    op(1'b0, 4'h0, 8'h00, 4'hF, 16'hFEDC, 1'b1);
    la = 0;
    lb = 0;
    for (int n = 0; n < 100 && !(rdy_a && rdy_b && n > 0); n++) begin
      @(negedge clk); #1;
      if (!rdy_a) la++;
      if (!rdy_b) lb++;
      if (rdy_a && rdy_b) set_in(1'b0, 4'h0, 8'h00, 4'h0, 16'h0000, 1'b0);
      else rand_in(1'b1);
    end
    check("clr_len_a", la, 16);
    check("clr_len_b", lb, 16);
    read_all();

    // Reset in the middle of a clear.
    op(1'b1, 4'd1, 8'h5A, 4'h0, 16'h0000, 1'b0);
    op(1'b0, 4'd0, 8'h00, 4'hF, 16'h1111, 1'b0);
    idle(3);
    op(1'b0, 4'h0, 8'h00, 4'h0, 16'h0000, 1'b1);
    idle(10);
    rst_n = 1'b0;
    #1;
    check("abort_dout_a", 32'(dout_a), 32'd0);
    check("abort_vld_a",  32'(vld_a),  32'd0);
    check("abort_dout_b", dout_b,      32'd0);
    check("abort_vld_b",  32'(vld_b),  32'd0);
    check("abort_rdy_b",  32'(rdy_b),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    measure_rdy(1, 16);
    read_all();

    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      rand_in(1'b0);
    end
    idle(5);
    for (int j = 0; j < 8; j++) check($sformatf("sb_empty_%0d", j), sb[j].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
